// File: rtl/wb_arb2_rr.sv
// Two-master round-robin Wishbone classic arbiter with strobe watchdog.
// Ports: m0_*/m1_* master sides, s_* shared slave side, grant_o owner.
module wb_arb2_rr #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  // master 0
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // shared slave
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  // owner
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic [1:0]  grant_q, grant_d;

  logic stb_sel;
  logic tmo;

  // Watchdog fires only when the slave stays silent this cycle.
  always_comb begin
    stb_sel = ((state_q == OWN0) & m0_stb_i)
            | ((state_q == OWN1) & m1_stb_i);
    tmo = stb_sel & ~s_ack_i & ~s_err_i
        & (wdog_q == WD_LAST);
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~tmo;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~tmo;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (stb_sel && !s_ack_i
                     && !s_err_i && !tmo) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (stb_sel && !s_ack_i
                     && !s_err_i && !tmo) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Decode of the next state so grant_o tracks state_q.
    grant_d = {state_d == OWN1, state_d == OWN0};
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Randomized and directed bench for wb_arb2_rr.
// Compares the DUT every cycle against an ownership/wait-count model.
module tb_wb_arb2_rr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic          m_we  [2];
  logic          m_cyc [2];
  logic          m_stb [2];
  logic [DW-1:0] s_dat;
  logic          s_ack;
  logic          s_err;

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_ack_o, m1_err_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]    grant_o;

  wb_arb2_rr #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .m0_adr_i (m_adr[0]),
    .m0_dat_i (m_dat[0]),
    .m0_sel_i (m_sel[0]),
    .m0_we_i  (m_we[0]),
    .m0_cyc_i (m_cyc[0]),
    .m0_stb_i (m_stb[0]),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_adr_i (m_adr[1]),
    .m1_dat_i (m_dat[1]),
    .m1_sel_i (m_sel[1]),
    .m1_we_i  (m_we[1]),
    .m1_cyc_i (m_cyc[1]),
    .m1_stb_i (m_stb[1]),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .grant_o  (grant_o)
  );

  // model: owner 0=none, 1=m0, 2=m1; wcnt = unanswered strobes so far
  int owner = 0;
  int last  = 1;
  int wcnt  = 0;
  bit got [2];
  int ntx [2];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // one clock: compare at negedge, advance model, return at posedge+1
  task automatic step();
    logic [1:0]  eg;
    logic [70:0] esb;
    logic [33:0] er [2];
    logic        to;
    int          n;
    @(negedge clk);
    eg    = 2'b00;
    esb   = '0;
    er[0] = '0;
    er[1] = '0;
    to    = 1'b0;
    n     = owner - 1;
    if (owner != 0) begin
      eg[n] = 1'b1;
      to = m_stb[n] && !s_ack && !s_err && (wcnt == TO - 1);
      esb = {m_adr[n], m_dat[n], m_sel[n], m_we[n],
             m_cyc[n], m_stb[n] && !to};
      er[n] = {s_dat, s_ack, s_err || to};
    end
    chk("grant", grant_o, eg);
    chk("slave_bus",
        {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o},
        esb);
    chk("m0_resp", {m0_dat_o, m0_ack_o, m0_err_o}, er[0]);
    chk("m1_resp", {m1_dat_o, m1_ack_o, m1_err_o}, er[1]);
    got[0] = er[0][1] || er[0][0];
    got[1] = er[1][1] || er[1][0];
    if (!rst_n) begin
      owner = 0;
      last  = 1;
      wcnt  = 0;
    end else if (owner == 0) begin
      wcnt = 0;
      if (m_cyc[0] && m_cyc[1]) owner = (last == 1) ? 1 : 2;
      else if (m_cyc[0]) owner = 1;
      else if (m_cyc[1]) owner = 2;
    end else if (!m_cyc[n]) begin
      owner = 0;
      last  = n;
      wcnt  = 0;
    end else if (m_stb[n] && !s_ack && !s_err && !to) begin
      wcnt = wcnt + 1;
    end else begin
      wcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int n);
    m_adr[n] = $urandom;
    m_dat[n] = $urandom;
    m_sel[n] = SW'($urandom_range(15));
    m_we[n]  = 1'($urandom_range(1));
  endtask

  task automatic rnd_master(input int n);
    if (!m_cyc[n]) begin
      if ($urandom_range(2) == 0) begin
        m_cyc[n] = 1'b1;
        m_stb[n] = 1'b1;
        ntx[n]   = $urandom_range(1, 3);
        new_req(n);
      end
    end else if (got[n]) begin
      ntx[n]--;
      if (ntx[n] <= 0) begin
        m_cyc[n] = 1'b0;
        m_stb[n] = 1'b0;
      end else begin
        new_req(n);
        m_stb[n] = ($urandom_range(3) != 0);
      end
    end else if (!m_stb[n] && $urandom_range(1) == 0) begin
      m_stb[n] = 1'b1;
    end
  endtask

  initial begin
    logic [1:0] eg;
    int         w;
    int         n;
    bit         slow;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0;
      m_dat[i] = '0;
      m_sel[i] = '0;
      m_we[i]  = 1'b0;
      m_cyc[i] = 1'b0;
      m_stb[i] = 1'b0;
      got[i]   = 1'b0;
      ntx[i]   = 0;
    end
    s_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_ack", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);

    // tie after reset goes to m0, read at 0x10
    rst_n = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h10;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h20;
    #1;
    chk("lat_grant", grant_o, 2'b00);
    chk("lat_scyc", s_cyc_o, 1'b0);
    step();
    s_ack = 1'b1;
    s_dat = 32'hDEADBEEF;
    #1;
    chk("tie_grant", grant_o, 2'b01);
    chk("rd_adr", s_adr_o, 32'h10);
    chk("rd_ack", m0_ack_o, 1'b1);
    chk("rd_dat", m0_dat_o, 32'hDEADBEEF);
    chk("rd_other", {m1_ack_o, m1_dat_o}, 33'h0);
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    s_ack = 1'b0;
    #1;
    chk("drop_scyc", s_cyc_o, 1'b0);
    step();
    #1;
    chk("dead_grant", grant_o, 2'b00);
    step();
    #1;
    chk("m1_grant", grant_o, 2'b10);
    chk("m1_adr", s_adr_o, 32'h20);

    // m1 holds for three writes while m0 waits
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h40;
    m_we[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_adr[1] = 32'h100 + i;
      m_dat[1] = $urandom;
      m_we[1]  = 1'b1;
      s_ack    = 1'b1;
      #1;
      chk("wr_adr", s_adr_o, 32'h100 + i);
      chk("wr_dat", s_dat_o, m_dat[1]);
      chk("wr_we", s_we_o, 1'b1);
      chk("wr_ack1", m1_ack_o, 1'b1);
      chk("wr_ack0", m0_ack_o, 1'b0);
      step();
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    s_ack = 1'b0;
    step();
    step();
    #1;
    chk("m0_after", grant_o, 2'b01);

    // slave silent: err on 8th strobe cycle only
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("to_err", m0_err_o, (k == 8));
      chk("to_stb", s_stb_o, (k != 8));
      chk("to_other", {m1_err_o, m1_ack_o}, 2'b00);
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    step();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();

    // reset during a pending m1 strobe
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    step();
    chk("pend_grant", grant_o, 2'b10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    chk("rm_grant", grant_o, 2'b00);
    chk("rm_scyc", s_cyc_o, 1'b0);
    chk("rm_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0);
    step();
    chk("rm_tie", grant_o, 2'b01);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();

    // continuous requests alternate ownership
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b1;
      m_stb[i] = 1'b1;
    end
    eg = 2'b01;
    for (int t = 0; t < 10; t++) begin
      w = 0;
      while (grant_o == 2'b00 && w < 5) begin
        step();
        w++;
      end
      chk("alt_wait", (w < 5), 1'b1);
      chk("alt_grant", grant_o, eg);
      n = eg[1] ? 1 : 0;
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
      step();
      m_cyc[n] = 1'b1; m_stb[n] = 1'b1;
      eg = ~eg;
    end
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0;
      m_stb[i] = 1'b0;
    end
    step();
    step();

    // random traffic with variable slave latency
    slow = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) slow = 1'($urandom_range(1));
      rst_n = ($urandom_range(399) != 0);
      rnd_master(0);
      rnd_master(1);
      s_dat = $urandom;
      s_ack = slow ? ($urandom_range(11) == 0)
                   : ($urandom_range(2) == 0);
      s_err = ($urandom_range(15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/wb_arb2_rr.md
WB_ARB2_RR -- requirements
Module: wb_arb2_rr

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (byte-select width DW/8).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of unacknowledged strobe cycles before a bus error (range 2..65535).
REQ-004 wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 wb_rst_ni  input  1  synchronous, active-low reset.
REQ-006 m{0,1}_adr_i  input  AW  master address.
REQ-007 m{0,1}_dat_i  input  DW  master write data.
REQ-008 m{0,1}_sel_i  input  DW/8  master byte selects.
REQ-009 m{0,1}_we_i  input  1  master write enable.
REQ-010 m{0,1}_cyc_i  input  1  master cycle request.
REQ-011 m{0,1}_stb_i  input  1  master strobe.
REQ-012 m{0,1}_dat_o  output  DW  read data returned to master.
REQ-013 m{0,1}_ack_o  output  1  acknowledge to master.
REQ-014 m{0,1}_err_o  output  1  error to master.
REQ-015 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  output  AW/DW/DW/8/1/1/1  shared-slave Wishbone classic master-side signals.
REQ-016 s_dat_i, s_ack_i, s_err_i  input  DW/1/1  shared-slave responses.
REQ-017 grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.

Function
REQ-018 SHALL implement FSM states IDLE, OWN0, OWN1, with a registered last_owner bit.
REQ-019 IDLE: if only mN_cyc_i is high, SHALL go to OWNn next edge; if both are high, SHALL go to the owner not equal to last_owner; if neither, SHALL stay IDLE.
REQ-020 Arbitration latency SHALL be exactly one cycle: s_cyc_o is first asserted the cycle after the request is seen in IDLE.
REQ-021 OWNn: s_adr_o/s_dat_o/s_sel_o/s_we_o/s_stb_o SHALL combinationally follow master n; s_cyc_o = mN_cyc_i.
REQ-022 In IDLE, s_cyc_o and s_stb_o SHALL be 0; other slave outputs SHALL be 0.
REQ-023 s_ack_i, s_err_i and s_dat_i SHALL route combinationally only to the owning master; the non-owner's ack_o/err_o SHALL be 0 and its dat_o SHALL be 0.
REQ-024 Ownership SHALL be held while the owner keeps cyc high across multiple strobes (no preemption).
REQ-025 When the owner drops cyc, the FSM SHALL return to IDLE at that edge, set last_owner = n, and not re-arbitrate in the same cycle (one dead cycle minimum between owners).
REQ-026 Watchdog: a 16-bit counter SHALL increment each cycle that s_stb_o=1 and s_ack_i=0 and s_err_i=0, and clear on ack, on err, on stb low, or on leaving OWNn.
REQ-027 When the counter equals TIMEOUT-1 with no ack/err, the owner's err_o SHALL pulse for exactly that cycle, s_stb_o SHALL be forced to 0 in that cycle, and the counter SHALL clear.
REQ-028 Simultaneous s_ack_i and s_err_i SHALL forward both unchanged; a timeout SHALL never be generated in a cycle where either is high.
REQ-029 grant_o SHALL be a registered decode of the FSM state.

Reset
REQ-030 With wb_rst_ni=0 at a clock edge: FSM = IDLE, last_owner = 1 (m0 wins the first tie), watchdog = 0, grant_o = 0; all s_* outputs and all ack_o/err_o SHALL read 0 in the following cycle.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no ack/err pulse issued to either master after the reset edge.

Verification
REQ-032 m0 and m1 raise cyc/stb in the same cycle after reset -> grant_o=01 next cycle; m0 read at 0x10 acked with dat 0xDEADBEEF; m0 drops cyc -> IDLE one cycle -> grant_o=10.
REQ-033 m1 holds cyc for 3 back-to-back writes while m0 requests -> all three writes reach the slave, m0 sees no ack until m1 releases.
REQ-034 Slave never acks, TIMEOUT=8 -> owner err_o pulses once on the 8th strobe cycle; the other master gets nothing.
REQ-035 Alternating continuous requests from both masters over 10 transfers -> grants strictly alternate 01,10,01,...
REQ-036 wb_rst_ni pulled low during an m1 pending strobe -> grant_o=00, s_cyc_o=0 next cycle, and the first tie after reset goes to m0.
